apb_bus_arbiter: RTL and testbench
==================================

# apb_bus_arbiter

Two-requester arbiter sharing the single internal APB master interface (transfer/ready/addr/wdata/write/rdata) between the RV32I core data port (requester 0) and a second bus agent such as DMA or debug (requester 1). It sits between the requesters and the APB master, which decodes to RAM, FND, UART, timer and GPIO slaves. Only one transfer is outstanding at any time. Grants are round-robin. Each granted request is latched, issued as a one-cycle trigger, and completed on the master's ready.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, WAIT cycles before error completion (only with APB_ARB_TIMEOUT_EN); legal range 1..255

Ports:
- PCLK  in  1  clock; single clock domain
- PRESET  in  1  asynchronous, active-low reset
- s_transfer[1:0]  in  2  per-requester request level; held until that requester's s_ready
- s_addr0 / s_addr1  in  ADDR_W  request address
- s_wdata0 / s_wdata1  in  DATA_W  write data
- s_write[1:0]  in  2  1 = write, 0 = read
- s_ready[1:0]  out  2  one-cycle completion pulse per requester
- s_rdata  out  DATA_W  read data; valid with s_ready
- s_err  out  1  error completion flag; valid with s_ready
- m_transfer  out  1  one-cycle trigger to the APB master
- m_addr  out  ADDR_W  latched address
- m_wdata  out  DATA_W  latched write data
- m_write  out  1  latched direction
- m_ready  in  1  completion from the APB master
- m_rdata  in  DATA_W  read data from the APB master
- grant_id  out  1  requester currently owning the bus; debug

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - If any s_transfer bit is high, select a winner, latch its addr/wdata/write into m_* registers, set grant_id, and go to ISSUE.
  - Otherwise stay in IDLE.
- Selection:
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- ISSUE: m_transfer = 1 for exactly this cycle; go to WAIT.
- WAIT: on m_ready:
  - s_ready[grant_id] = 1, s_rdata = m_rdata, s_err = 0.
  - last_grant <= grant_id; go to IDLE.
- s_ready and s_rdata are combinational from m_ready/m_rdata in WAIT, gated by grant_id. The non-granted s_ready bit is always 0.
- s_rdata = 0 whenever s_ready is low.
- Requesters must deassert s_transfer in the cycle after their s_ready unless issuing a new request. A high level in IDLE is always a new request.
- A requester whose transfer arrives while the other is being served waits; its inputs are sampled only in IDLE.
- m_addr, m_wdata and m_write hold their values from IDLE-exit until the next IDLE-exit.

## Timing
- Reset (PRESET low, asynchronous):
  - state = IDLE, last_grant = 1, grant_id = 0.
  - m_transfer = 0; m_addr, m_wdata, m_write = 0.
  - s_ready = 0, s_err = 0, s_rdata = 0; timeout counter = 0.
- Reset mid-transfer aborts silently: no s_ready is produced, and the APB master must be reset by the same PRESET.
- Request seen at edge N (IDLE) → m_transfer high in cycle N+1 → WAIT from N+2.
- s_ready appears in the same cycle m_ready is seen in WAIT.
- Minimum request-to-ready: 2 cycles plus slave latency.
- Back-to-back: after completion at cycle C, the next request issues m_transfer at C+2, so bus occupancy is 3 cycles per transfer minimum.
- m_ready outside WAIT is ignored.

## Configuration
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without m_ready, the arbiter pulses s_ready[grant_id] with s_err = 1 and s_rdata = 0, updates last_grant, and goes to DRAIN.
  - DRAIN waits for m_ready, discards it (no s_ready), then returns to IDLE.
  - m_ready on the exact timeout cycle counts as normal completion: s_err = 0.
- Undefined:
  - No counter and no DRAIN state; WAIT waits indefinitely.
  - s_err is tied to 0 and the TIMEOUT parameter is unused.

## Structure
- Package apb_arb_pkg holds:
  - arb_state_e enum (IDLE, ISSUE, WAIT, DRAIN)
  - grant_t (1 bit)
  - DEFAULT_TIMEOUT = 255
- Sub-module apb_arb_rr_pick: combinational 2-way round-robin pick. Inputs are the request vector and last_grant; outputs are the winner index and a valid flag.
- The FSM, latches and timeout logic live in the top module.

## Test plan
- Single read, requester 0: addr 0x1000_0004, m_ready after 1 cycle with m_rdata 0x0000_00A5 → m_transfer pulses once, then s_ready[0] with s_rdata 0xA5 and s_err 0.
- Simultaneous requests right after reset: requester 0 writes 0x11 to 0x1000_2000, requester 1 writes 0x22 to 0x1000_3000 → requester 0 is served first, then requester 1; two m_transfer pulses carrying matching m_addr/m_wdata.
- Both requesters hold requests continuously for 6 transfers → grants alternate 0,1,0,1,0,1 and s_ready never appears on the non-granted bit.
- Slave stalls 10 cycles (m_ready held low) → m_addr/m_write stay stable, no extra m_transfer, s_ready appears in the m_ready cycle.
- APB_ARB_TIMEOUT_EN with TIMEOUT = 4 and m_ready never asserted → after 4 WAIT cycles s_ready[grant_id] = 1, s_err = 1, s_rdata = 0. A later m_ready is absorbed in DRAIN with no s_ready; the next request is then served normally.
- PRESET pulsed low during WAIT → all outputs return to reset values immediately; after release, a pending requester 1 request is granted fresh.

Source files
------------

// File: rtl/apb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_arb_pkg : shared types and defaults for the APB bus arbiter      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  typedef logic grant_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/apb_arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_arb_rr_pick : combinational two-way round-robin winner select    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module apb_arb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_t     last_grant_i,
  output grant_t     winner_o,
  output logic       valid_o
);

  // Under contention the requester not served last wins; otherwise the lone requester.
  assign valid_o  = |req_i;
  assign winner_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];

endmodule
`default_nettype wire

// File: rtl/apb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_bus_arbiter : shares one APB master port between two requesters  |
// | Optional WAIT timeout with error completion: APB_ARB_TIMEOUT_EN      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module apb_bus_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [1:0]        s_transfer,
  input  logic [ADDR_W-1:0] s_addr0,
  input  logic [ADDR_W-1:0] s_addr1,
  input  logic [DATA_W-1:0] s_wdata0,
  input  logic [DATA_W-1:0] s_wdata1,
  input  logic [1:0]        s_write,
  output logic [1:0]        s_ready,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_err,
  output logic              m_transfer,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_write,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              grant_id
);

  arb_state_e        state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  grant_t            pick_id;
  logic              pick_vld;

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
`else
  localparam int c_unused_timeout = TIMEOUT;
`endif

  apb_arb_rr_pick u_pick (
    .req_i        (s_transfer),
    .last_grant_i (last_q),
    .winner_o     (pick_id),
    .valid_o      (pick_vld)
  );

  assign m_transfer = (state_q == ISSUE);
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign m_write    = write_q;
  assign grant_id   = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    s_ready = 2'b00;
    s_rdata = '0;
    s_err   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_id;
          addr_d  = pick_id ? s_addr1  : s_addr0;
          wdata_d = pick_id ? s_wdata1 : s_wdata0;
          write_d = s_write[pick_id];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      WAIT: begin
        // A ready on the timeout cycle itself still wins as a normal completion.
        if (m_ready) begin
          s_ready = grant_q ? 2'b10 : 2'b01;
          s_rdata = m_rdata;
          last_d  = grant_q;
          state_d = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT)) begin
          s_ready = grant_q ? 2'b10 : 2'b01;
          s_err   = 1'b1;
          last_d  = grant_q;
          state_d = DRAIN;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      DRAIN: begin
`ifdef APB_ARB_TIMEOUT_EN
        if (m_ready) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_bus_arbiter : randomized self-checking bench for the arbiter  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_apb_bus_arbiter;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  s_transfer;
  logic [31:0] s_addr0, s_addr1, s_wdata0, s_wdata1;
  logic [1:0]  s_write;
  logic [1:0]  s_ready;
  logic [31:0] s_rdata;
  logic        s_err;
  logic        m_transfer;
  logic [31:0] m_addr, m_wdata;
  logic        m_write;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        grant_id;

  logic [31:0] ta [2];
  logic [31:0] td [2];
  logic        tw [2];
  logic        model_last;
  int          n_checks;
  int          n_fail;

  assign s_addr0  = ta[0];
  assign s_addr1  = ta[1];
  assign s_wdata0 = td[0];
  assign s_wdata1 = td[1];
  assign s_write  = {tw[1], tw[0]};

  apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .s_transfer(s_transfer),
    .s_addr0(s_addr0), .s_addr1(s_addr1), .s_wdata0(s_wdata0), .s_wdata1(s_wdata1),
    .s_write(s_write), .s_ready(s_ready), .s_rdata(s_rdata), .s_err(s_err),
    .m_transfer(m_transfer), .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write),
    .m_ready(m_ready), .m_rdata(m_rdata), .grant_id(grant_id)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] d, input logic w);
    ta[id] = a;
    td[id] = d;
    tw[id] = w;
  endtask

  // Waits for the trigger, plays the slave with lat stall cycles, returns observations.
  task automatic serve(input int lat, input logic [31:0] rd, input logic [1:0] keep,
                       output logic found, output logic gid, output logic [31:0] addr,
                       output logic [31:0] wd, output logic wr, output int bad,
                       output logic [1:0] rdy, output logic [31:0] rdo, output logic err);
    found = 1'b0; gid = 1'b0; addr = '0; wd = '0; wr = 1'b0; bad = 0;
    rdy = 2'b00; rdo = '0; err = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge PCLK);
      if (m_transfer === 1'b1) found = 1'b1;
    end
    if (!found) return;
    gid = grant_id; addr = m_addr; wd = m_wdata; wr = m_write;
    m_ready = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge PCLK);
      if (m_transfer !== 1'b0 || s_ready !== 2'b00 || m_addr !== addr ||
          m_wdata !== wd || m_write !== wr) bad++;
    end
    @(negedge PCLK);
    if (m_transfer !== 1'b0) bad++;
    m_ready = 1'b1;
    m_rdata = rd;
    #1;
    rdy = s_ready; rdo = s_rdata; err = s_err;
    @(negedge PCLK);
    m_ready = 1'b0;
    m_rdata = $urandom;
    if (s_ready !== 2'b00 || s_rdata !== 32'h0) bad++;
    if (!keep[gid]) s_transfer[gid] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    logic [102:0] act;
    PRESET = 1'b0; s_transfer = 2'b00; m_ready = 1'b0; m_rdata = 32'hCAFE_F00D;
    set_req(0, 32'h0, 32'h0, 1'b0);
    set_req(1, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge PCLK);
    act = {m_transfer, m_addr, m_wdata, m_write, s_ready, s_rdata, s_err, grant_id};
    n_checks++;
    if (act !== '0) begin n_fail++; $display("FAIL reset_in got %h exp 0", act); end
    PRESET = 1'b1;
    model_last = 1'b1;
    repeat (2) @(negedge PCLK);
    act = {m_transfer, m_addr, m_wdata, m_write, s_ready, s_rdata, s_err, grant_id};
    n_checks++;
    if (act !== '0) begin n_fail++; $display("FAIL reset_out got %h exp 0", act); end
    m_ready = 1'b1;
    #1;
    n_checks++;
    if ({s_ready, s_rdata, m_transfer} !== '0) begin
      n_fail++; $display("FAIL idle_ready got %h/%h exp 0/0", s_ready, s_rdata);
    end
    @(negedge PCLK);
    m_ready = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if (m_transfer !== 1'b0) begin n_fail++; $display("FAIL idle_ready_trig got %b exp 0", m_transfer); end
  endtask

  task automatic test_contention();
    logic f, g, w, e; logic [31:0] a, d, r; int b; logic [1:0] y;
    logic [102:0] act, exp;
    apply_reset();
    set_req(0, 32'h1000_2000, 32'h11, 1'b1);
    set_req(1, 32'h1000_3000, 32'h22, 1'b1);
    s_transfer = 2'b11;
    for (int k = 0; k < 2; k++) begin
      logic eg;
      eg = ~model_last;
      serve(1, 32'h0, 2'b00, f, g, a, d, w, b, y, r, e);
      act = {f, g, a, d, w, (b == 0), y, r, e};
      exp = {1'b1, eg, ta[eg], td[eg], 1'b1, 1'b1, eg ? 2'b10 : 2'b01, 32'h0, 1'b0};
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL contention_%0d got %h exp %h", k, act, exp); end
      model_last = eg;
    end
  endtask

  task automatic test_alternate();
    logic f, g, w, e; logic [31:0] a, d, r, rd; int b; logic [1:0] y;
    logic [102:0] act, exp;
    logic eg;
    for (int i = 0; i < 2; i++) set_req(i, $urandom, $urandom, 1'($urandom));
    s_transfer = 2'b11;
    for (int i = 0; i < 6; i++) begin
      eg = (s_transfer == 2'b11) ? ~model_last : s_transfer[1];
      exp = {1'b1, eg, ta[eg], td[eg], tw[eg], 1'b1, eg ? 2'b10 : 2'b01, 32'h0, 1'b0};
      rd = $urandom;
      exp[32:1] = rd;
      serve($urandom_range(0, 2), rd, (i < 4) ? 2'b11 : 2'b00, f, g, a, d, w, b, y, r, e);
      act = {f, g, a, d, w, (b == 0), y, r, e};
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL alternate_%0d got %h exp %h", i, act, exp); end
      model_last = eg;
      if (i < 4) set_req(eg, $urandom, $urandom, 1'($urandom));
    end
  endtask

  task automatic test_single_read();
    logic f, g, w, e; logic [31:0] a, d, r; int b; logic [1:0] y;
    logic [102:0] act, exp;
    set_req(0, 32'h1000_0004, 32'h5555_AAAA, 1'b0);
    s_transfer = 2'b01;
    serve(1, 32'h0000_00A5, 2'b00, f, g, a, d, w, b, y, r, e);
    act = {f, g, a, d, w, (b == 0), y, r, e};
    exp = {1'b1, 1'b0, 32'h1000_0004, 32'h5555_AAAA, 1'b0, 1'b1, 2'b01, 32'h0000_00A5, 1'b0};
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL single_read got %h exp %h", act, exp); end
    model_last = 1'b0;
  endtask

  task automatic test_stall();
    logic f, g, w, e; logic [31:0] a, d, r; int b; logic [1:0] y;
    logic [102:0] act, exp;
    set_req(1, 32'h4000_0010, 32'h1234_5678, 1'b1);
    s_transfer = 2'b10;
    serve(10, 32'h0BAD_BEEF, 2'b00, f, g, a, d, w, b, y, r, e);
    act = {f, g, a, d, w, (b == 0), y, r, e};
    exp = {1'b1, 1'b1, 32'h4000_0010, 32'h1234_5678, 1'b1, 1'b1, 2'b10, 32'h0BAD_BEEF, 1'b0};
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL stall got %h exp %h bad=%0d", act, exp, b); end
    model_last = 1'b1;
    repeat (3) @(negedge PCLK);
    n_checks++;
    if ({m_addr, m_write} !== {32'h4000_0010, 1'b1}) begin
      n_fail++; $display("FAIL hold_after got %h/%b exp 40000010/1", m_addr, m_write);
    end
  endtask

  task automatic test_random();
    logic f, g, w, e; logic [31:0] a, d, r, rd; int b; logic [1:0] y;
    logic [102:0] act, exp;
    logic [1:0] pat;
    logic eg;
    for (int it = 0; it < 16; it++) begin
      pat = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) set_req(i, $urandom, $urandom, 1'($urandom));
      s_transfer = pat;
      for (int k = 0; k < ((pat == 2'b11) ? 2 : 1); k++) begin
        eg = (s_transfer == 2'b11) ? ~model_last : s_transfer[1];
        rd = $urandom;
        exp = {1'b1, eg, ta[eg], td[eg], tw[eg], 1'b1, eg ? 2'b10 : 2'b01, rd, 1'b0};
        serve($urandom_range(0, 3), rd, 2'b00, f, g, a, d, w, b, y, r, e);
        act = {f, g, a, d, w, (b == 0), y, r, e};
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL random_%0d_%0d got %h exp %h", it, k, act, exp); end
        model_last = eg;
      end
      if ($urandom_range(0, 1) == 1) @(negedge PCLK);
    end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic f, g, w, e; logic [31:0] a, d, r; int b; logic [1:0] y;
    logic [102:0] act, exp;
    int waits;
    logic seen;
    set_req(0, 32'h2000_0000, 32'h0, 1'b0);
    s_transfer = 2'b01;
    m_rdata = 32'hDEAD_BEEF;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge PCLK); seen = (m_transfer === 1'b1); end
    waits = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK); waits++;
      if (s_ready !== 2'b00) seen = 1'b1;
    end
    n_checks++;
    if ({seen, waits[7:0], s_ready, s_err, s_rdata} !== {1'b1, 8'(TB_TIMEOUT + 1), 2'b01, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL timeout got w=%0d rdy=%b err=%b rd=%h", waits, s_ready, s_err, s_rdata);
    end
    model_last = 1'b0;
    @(negedge PCLK);
    s_transfer = 2'b00;
    repeat (3) @(negedge PCLK);
    m_ready = 1'b1;
    #1;
    n_checks++;
    if ({s_ready, s_err, m_transfer} !== 4'b0) begin
      n_fail++; $display("FAIL drain got rdy=%b err=%b exp 00/0", s_ready, s_err);
    end
    @(negedge PCLK);
    m_ready = 1'b0;
    set_req(1, 32'h2000_0100, 32'h77, 1'b1);
    s_transfer = 2'b10;
    serve(0, 32'h5, 2'b00, f, g, a, d, w, b, y, r, e);
    act = {f, g, a, d, w, (b == 0), y, r, e};
    exp = {1'b1, 1'b1, 32'h2000_0100, 32'h77, 1'b1, 1'b1, 2'b10, 32'h5, 1'b0};
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL after_drain got %h exp %h", act, exp); end
    model_last = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    logic f, g, w, e; logic [31:0] a, d, r; int b; logic [1:0] y;
    logic [102:0] act, exp;
    logic seen;
    set_req(0, 32'h3000_0000, 32'h99, 1'b1);
    s_transfer = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge PCLK); seen = (m_transfer === 1'b1); end
    @(negedge PCLK);
    set_req(1, 32'h3000_0040, 32'h66, 1'b0);
    s_transfer = 2'b11;
    m_ready = 1'b1;
    PRESET = 1'b0;
    #1;
    n_checks++;
    if ({seen, m_transfer, m_addr, m_wdata, m_write, s_ready, s_rdata, s_err, grant_id} !== {1'b1, 102'h0}) begin
      n_fail++; $display("FAIL reset_mid got addr=%h rdy=%b gid=%b seen=%b", m_addr, s_ready, grant_id, seen);
    end
    @(negedge PCLK);
    m_ready = 1'b0;
    s_transfer = 2'b10;
    PRESET = 1'b1;
    model_last = 1'b1;
    serve(2, 32'h0000_0042, 2'b00, f, g, a, d, w, b, y, r, e);
    act = {f, g, a, d, w, (b == 0), y, r, e};
    exp = {1'b1, 1'b1, 32'h3000_0040, 32'h66, 1'b0, 1'b1, 2'b10, 32'h0000_0042, 1'b0};
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_regrant got %h exp %h", act, exp); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_last = 1'b1;
    test_reset();
    test_contention();
    test_alternate();
    test_single_read();
    test_stall();
    test_random();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    repeat (2) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
